// File: rtl/gray_ctr_pkg.sv
// Shared types and helpers for the up/down Gray counter.
// bin2gray works on a wide vector; callers size-cast the result to their width.
package gray_ctr_pkg;

  typedef enum logic {DIR_DOWN, DIR_UP} dir_e;

  localparam bit MODE_WRAP = 1'b0;
  localparam bit MODE_SAT  = 1'b1;

  localparam int GRAY_MAXW = 64;

  function automatic logic [GRAY_MAXW-1:0] bin2gray(input logic [GRAY_MAXW-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_ctr_updown_gray_to_bin.sv
// Combinational Gray-to-binary decode: each binary bit is the XOR of all
// Gray bits at or above its position.
module gray_to_bin #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_ctr_updown.sv
// Up/down Gray counter with clear, Gray-coded load and wrap/saturate mode.
// q_gray comes straight from its own flop so it is safe to sample across clock domains.
module gray_ctr_updown
  import gray_ctr_pkg::*;
#(
  parameter int              WIDTH     = 5,
  parameter bit              SATURATE  = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q_gray,
  output logic [WIDTH-1:0] q_bin,
  output logic             wrap,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH-1:0] MAX_VAL    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);
  localparam logic [WIDTH-1:0] RESET_GRAY = WIDTH'(bin2gray(GRAY_MAXW'(RESET_VAL)));
  localparam bit               SAT_MODE   = (SATURATE == MODE_SAT);

  logic [WIDTH-1:0] ld_bin;
  logic [WIDTH-1:0] next_bin;
  logic [WIDTH-1:0] next_gray;
  logic             next_wrap;
  dir_e             dir;

  gray_to_bin #(.WIDTH(WIDTH)) u_ld_dec (
    .gray (ld_val),
    .bin  (ld_bin)
  );

  assign dir = up ? DIR_UP : DIR_DOWN;

  always_comb begin
    next_bin  = q_bin;
    next_wrap = 1'b0;
    if (clr) begin
      next_bin = RESET_VAL;
    end else if (ld) begin
      next_bin = ld_bin;
    end else if (en) begin
      if (dir == DIR_UP) begin
        if (q_bin == MAX_VAL) begin
          // Saturating mode simply keeps the current value at the end stop.
          if (!SAT_MODE) begin
            next_bin  = '0;
            next_wrap = 1'b1;
          end
        end else begin
          next_bin = q_bin + ONE;
        end
      end else begin
        if (q_bin == '0) begin
          if (!SAT_MODE) begin
            next_bin  = MAX_VAL;
            next_wrap = 1'b1;
          end
        end else begin
          next_bin = q_bin - ONE;
        end
      end
    end
  end

  assign next_gray = WIDTH'(bin2gray(GRAY_MAXW'(next_bin)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_bin  <= RESET_VAL;
      q_gray <= RESET_GRAY;
      wrap   <= 1'b0;
    end else begin
      q_bin  <= next_bin;
      q_gray <= next_gray;
      wrap   <= next_wrap;
    end
  end

  assign at_max = (q_bin == MAX_VAL);
  assign at_min = (q_bin == '0);

endmodule

// File: tb/tb_gray_ctr_updown.sv
// Directed vector table plus hand sequences and a random scoreboard run
// across wrap, saturate and non-zero reset-value instances of the counter.
module tb_gray_ctr_updown;

  localparam int NI = 3;   // 0: wrap, 1: saturate, 2: wrap with RESET_VAL=5

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clr, ld, en, up;
  logic [3:0] ld_val;
  logic [3:0] qg [NI];
  logic [3:0] qb [NI];
  logic       wr [NI];
  logic       amax [NI];
  logic       amin [NI];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gray_ctr_updown #(.WIDTH(4), .SATURATE(1'b0), .RESET_VAL(4'd0)) u_w (
    .clk(clk), .reset_n(reset_n), .clr(clr), .ld(ld), .ld_val(ld_val), .en(en), .up(up),
    .q_gray(qg[0]), .q_bin(qb[0]), .wrap(wr[0]), .at_max(amax[0]), .at_min(amin[0]));

  gray_ctr_updown #(.WIDTH(4), .SATURATE(1'b1), .RESET_VAL(4'd0)) u_s (
    .clk(clk), .reset_n(reset_n), .clr(clr), .ld(ld), .ld_val(ld_val), .en(en), .up(up),
    .q_gray(qg[1]), .q_bin(qb[1]), .wrap(wr[1]), .at_max(amax[1]), .at_min(amin[1]));

  gray_ctr_updown #(.WIDTH(4), .SATURATE(1'b0), .RESET_VAL(4'd5)) u_r (
    .clk(clk), .reset_n(reset_n), .clr(clr), .ld(ld), .ld_val(ld_val), .en(en), .up(up),
    .q_gray(qg[2]), .q_bin(qb[2]), .wrap(wr[2]), .at_max(amax[2]), .at_min(amin[2]));

  typedef struct {
    logic       clr, ld, en, up;
    logic [3:0] ld_val;
    logic [3:0] e_bin, e_gray;
    logic       e_wrap, e_max, e_min;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic c, input logic l, input logic e, input logic u,
                              input logic [3:0] lv, input logic [3:0] b, input logic [3:0] g,
                              input logic w, input logic mx, input logic mn);
    vec_t v;
    v.clr = c; v.ld = l; v.en = e; v.up = u; v.ld_val = lv;
    v.e_bin = b; v.e_gray = g; v.e_wrap = w; v.e_max = mx; v.e_min = mn;
    return v;
  endfunction

  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic drive(input logic c, input logic l, input logic e, input logic u, input logic [3:0] lv);
    clr = c; ld = l; en = e; up = u; ld_val = lv;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // reference model state
  logic [3:0] mb [NI];
  logic       mw [NI];
  logic       msat [NI];
  logic [3:0] mrv [NI];

  task automatic model_step(input int k);
    logic [3:0] b;
    logic       w;
    b = mb[k];
    w = 1'b0;
    if (clr)      b = mrv[k];
    else if (ld)  b = g2b(ld_val);
    else if (en) begin
      if (up) begin
        if (mb[k] == 4'hF) begin
          if (!msat[k]) begin b = 4'h0; w = 1'b1; end
        end else b = mb[k] + 4'd1;
      end else begin
        if (mb[k] == 4'h0) begin
          if (!msat[k]) begin b = 4'hF; w = 1'b1; end
        end else b = mb[k] - 4'd1;
      end
    end
    mb[k] = b;
    mw[k] = w;
  endtask

  logic [3:0] gseq [16] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                            4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

  initial begin
    logic [3:0] prev_g [NI];
    logic       c, l, e, u;
    logic [3:0] lv;

    reset_n = 1'b0;
    drive(0, 0, 0, 0, 4'h0);

    // 16 up steps from reset, then directed boundary rows
    for (int i = 0; i < 16; i++)
      vecs.push_back(mk(0, 0, 1, 1, 4'h0, 4'((i + 1) % 16), gseq[i], i == 15, i == 14, i == 15));
    vecs.push_back(mk(0, 0, 1, 0, 4'h0, 4'hF, 4'h8, 1, 1, 0));  // 0 -> max wraps
    vecs.push_back(mk(0, 0, 0, 0, 4'h0, 4'hF, 4'h8, 0, 1, 0));  // hold, pulse gone
    vecs.push_back(mk(0, 1, 1, 1, 4'hC, 4'h8, 4'hC, 0, 0, 0));  // load beats count
    vecs.push_back(mk(0, 0, 1, 1, 4'h0, 4'h9, 4'hD, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 4'h8, 4'hF, 4'h8, 0, 1, 0));  // load max
    vecs.push_back(mk(0, 1, 1, 1, 4'h0, 4'h0, 4'h0, 0, 0, 1));  // load suppresses wrap step
    vecs.push_back(mk(0, 0, 1, 1, 4'h0, 4'h1, 4'h1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 4'hC, 4'h0, 4'h0, 0, 0, 1));  // clear beats load
    vecs.push_back(mk(0, 0, 1, 0, 4'h0, 4'hF, 4'h8, 1, 1, 0));
    vecs.push_back(mk(1, 0, 1, 1, 4'h0, 4'h0, 4'h0, 0, 0, 1));  // clear suppresses wrap step

    repeat (2) @(posedge clk);
    #1;
    chk("rst_bin", 32'(qb[0]), 32'h0);
    chk("rst_gray", 32'(qg[0]), 32'h0);
    chk("rst_wrap", 32'(wr[0]), 32'h0);
    chk("rst_min", 32'(amin[0]), 32'h1);
    chk("rst_bin_rv5", 32'(qb[2]), 32'h5);
    chk("rst_gray_rv5", 32'(qg[2]), 32'h7);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].clr, vecs[i].ld, vecs[i].en, vecs[i].up, vecs[i].ld_val);
      step();
      chk($sformatf("vec%0d_bin", i), 32'(qb[0]), 32'(vecs[i].e_bin));
      chk($sformatf("vec%0d_gray", i), 32'(qg[0]), 32'(vecs[i].e_gray));
      chk($sformatf("vec%0d_wrap", i), 32'(wr[0]), 32'(vecs[i].e_wrap));
      chk($sformatf("vec%0d_max", i), 32'(amax[0]), 32'(vecs[i].e_max));
      chk($sformatf("vec%0d_min", i), 32'(amin[0]), 32'(vecs[i].e_min));
    end

    // saturate: load max, hold on up, then step down
    drive(0, 1, 0, 0, 4'h8);
    step();
    chk("sat_ld_bin", 32'(qb[1]), 32'hF);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 1, 4'h0);
      step();
      chk($sformatf("sat_hold%0d_bin", i), 32'(qb[1]), 32'hF);
      chk($sformatf("sat_hold%0d_gray", i), 32'(qg[1]), 32'h8);
      chk($sformatf("sat_hold%0d_wrap", i), 32'(wr[1]), 32'h0);
    end
    drive(0, 0, 1, 0, 4'h0);
    step();
    chk("sat_down_bin", 32'(qb[1]), 32'hE);
    chk("sat_down_gray", 32'(qg[1]), 32'h9);
    drive(0, 1, 0, 0, 4'h0);
    step();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1, 0, 4'h0);
      step();
      chk($sformatf("sat_min%0d_bin", i), 32'(qb[1]), 32'h0);
      chk($sformatf("sat_min%0d_wrap", i), 32'(wr[1]), 32'h0);
    end

    // clr beats ld and en; then async reset mid-count
    drive(1, 1, 1, 1, 4'hC);
    step();
    chk("clr_rv5_bin", 32'(qb[2]), 32'h5);
    chk("clr_rv5_gray", 32'(qg[2]), 32'h7);
    drive(0, 0, 1, 1, 4'h0);
    repeat (3) step();
    chk("cnt_rv5_bin", 32'(qb[2]), 32'h8);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rv5_bin", 32'(qb[2]), 32'h5);
    chk("async_rv5_gray", 32'(qg[2]), 32'h7);
    chk("async_w_bin", 32'(qb[0]), 32'h0);
    chk("async_w_wrap", 32'(wr[0]), 32'h0);
    drive(0, 0, 0, 0, 4'h0);
    step();
    reset_n = 1'b1;

    // random scoreboard run
    for (int k = 0; k < NI; k++) begin
      msat[k] = (k == 1);
      mrv[k]  = (k == 2) ? 4'd5 : 4'd0;
      mb[k]   = mrv[k];
      mw[k]   = 1'b0;
      prev_g[k] = qg[k];
    end
    for (int t = 0; t < 2000; t++) begin
      c  = ($urandom_range(0, 19) == 0);
      l  = ($urandom_range(0, 9) == 0);
      e  = ($urandom_range(0, 9) < 7);
      u  = 1'($urandom_range(0, 1));
      lv = 4'($urandom_range(0, 15));
      drive(c, l, e, u, lv);
      for (int k = 0; k < NI; k++) model_step(k);
      step();
      for (int k = 0; k < NI; k++) begin
        chk($sformatf("rnd%0d_i%0d_bin", t, k), 32'(qb[k]), 32'(mb[k]));
        chk($sformatf("rnd%0d_i%0d_wrap", t, k), 32'(wr[k]), 32'(mw[k]));
        chk($sformatf("rnd%0d_i%0d_gray", t, k), 32'(qg[k]), 32'(mb[k] ^ (mb[k] >> 1)));
        chk($sformatf("rnd%0d_i%0d_max", t, k), 32'(amax[k]), 32'(mb[k] == 4'hF));
        chk($sformatf("rnd%0d_i%0d_min", t, k), 32'(amin[k]), 32'(mb[k] == 4'h0));
        if (!c && !l)
          chk($sformatf("rnd%0d_i%0d_hamming_le1", t, k),
              32'($countones(qg[k] ^ prev_g[k]) <= 1), 32'h1);
        prev_g[k] = qg[k];
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
